fetch_stage: RTL and testbench

- First pipeline stage. Owns the program counter, issues one instruction-memory read at a time, and presents {PC, instruction} to the decode stage through the standard stall/done handshake.
- Accepts redirects (taken branch/jump target) from the top level. On a redirect it squashes any held or in-flight fetch.
- Sits directly upstream of decode_stage: feeds program_count_in and instruction_data_in.

---
 rtl/pipeline_pkg.sv | 8 +
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types and constants
package pipeline_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int INSTRUCTION_BYTES = 4;
  localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues one imem read at a time, holds {pc, instr} for decode
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         next_stall,
  output logic                         done_next,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_target,
  output logic                         imem_req_valid,
  output logic [ADDR_WIDTH-1:0]        imem_req_addr,
  input  logic                         imem_req_ready,
  input  logic                         imem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
  input  logic                         imem_resp_error,
  output logic [ADDR_WIDTH-1:0]        program_count_out,
  output logic                         program_count_valid_out,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_data_out,
  output logic                         instruction_data_valid_out
);
  fetch_state_t state;
  logic [ADDR_WIDTH-1:0] pc;
  logic stale;
  logic aligned;
  assign aligned = pc[1:0] == 2'b00;
  assign done_next = !rst && !redirect_valid && state == HOLD;
  assign imem_req_valid = !rst && !redirect_valid && state == IDLE && aligned;
  assign imem_req_addr = pc;
  assign program_count_out = pc;
  // pc only changes on transfer or redirect, so it doubles as the held entry's PC
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_VECTOR;
      stale <= 1'b0;
      program_count_valid_out <= 1'b0;
      instruction_data_valid_out <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_target;
      program_count_valid_out <= 1'b0;
      instruction_data_valid_out <= 1'b0;
      stale <= state == WAIT && !imem_resp_valid;
      state <= (state == WAIT && !imem_resp_valid) ? WAIT : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!aligned) begin
            program_count_valid_out <= 1'b1;
            instruction_data_valid_out <= 1'b0;
            state <= HOLD;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid && stale) begin
            stale <= 1'b0;
            state <= IDLE;
          end else if (imem_resp_valid) begin
            instruction_data_out <= imem_resp_data;
            program_count_valid_out <= 1'b1;
            instruction_data_valid_out <= !imem_resp_error;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!next_stall) begin
            pc <= pc + ADDR_WIDTH'(INSTRUCTION_BYTES);
            program_count_valid_out <= 1'b0;
            instruction_data_valid_out <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random memory/stall/redirect stimulus against a PC-sequence reference model
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic next_stall = 1'b0;
  logic done_next;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic imem_req_valid;
  logic [31:0] imem_req_addr;
  logic imem_req_ready = 1'b0;
  logic imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic imem_resp_error = 1'b0;
  logic [31:0] program_count_out;
  logic program_count_valid_out;
  logic [31:0] instruction_data_out;
  logic instruction_data_valid_out;
  int checks = 0;
  int failures = 0;
  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .next_stall(next_stall),
    .done_next(done_next),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .imem_resp_error(imem_resp_error),
    .program_count_out(program_count_out),
    .program_count_valid_out(program_count_valid_out),
    .instruction_data_out(instruction_data_out),
    .instruction_data_valid_out(instruction_data_valid_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction
  function automatic logic mem_err(input logic [31:0] a);
    return a[5:2] == 4'd3;
  endfunction
  initial begin
    logic [31:0] model_pc;
    logic [31:0] pend_addr;
    logic [31:0] prev_instr;
    logic exp_idv;
    bit pending;
    bit prev_hold;
    int cnt;
    int transfers;
    model_pc = 32'h0;
    pend_addr = '0;
    prev_instr = '0;
    pending = 0;
    prev_hold = 0;
    cnt = 0;
    transfers = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || ($urandom_range(0, 399) == 0);
      redirect_valid = !rst && cyc > 3 && $urandom_range(0, 19) == 0;
      case ($urandom_range(0, 3))
        0: redirect_target = 32'($urandom_range(0, 255)) << 2;
        1: redirect_target = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        2: redirect_target = $urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFF4;
        default: redirect_target = 32'h0000_0100;
      endcase
      next_stall = $urandom_range(0, 2) == 0;
      imem_req_ready = $urandom_range(0, 1) == 1;
      imem_resp_valid = pending && cnt == 0;
      imem_resp_data = imem_resp_valid ? mem_data(pend_addr) : $urandom;
      imem_resp_error = imem_resp_valid ? mem_err(pend_addr) : 1'($urandom_range(0, 1));
      #1;
      if (rst) begin
        check("rst_done", 32'(done_next), 32'd0);
        check("rst_req", 32'(imem_req_valid), 32'd0);
        pending = 0;
        prev_hold = 0;
        model_pc = 32'h0;
      end else begin
        if (cyc == 2) begin
          check("post_rst_pcv", 32'(program_count_valid_out), 32'd0);
          check("post_rst_idv", 32'(instruction_data_valid_out), 32'd0);
          check("post_rst_req", 32'(imem_req_valid), 32'd1);
        end
        if (prev_hold && !redirect_valid) begin
          check("stall_done", 32'(done_next), 32'd1);
          check("stall_instr", instruction_data_out, prev_instr);
        end
        prev_hold = 0;
        if (imem_resp_valid) pending = 0;
        else if (pending) cnt--;
        if (redirect_valid) begin
          check("redir_done", 32'(done_next), 32'd0);
          check("redir_req", 32'(imem_req_valid), 32'd0);
          model_pc = redirect_target;
        end else begin
          if (imem_req_valid) begin
            check("req_addr", imem_req_addr, model_pc);
            check("req_single", 32'(pending), 32'd0);
            if (imem_req_ready) begin
              pending = 1;
              pend_addr = imem_req_addr;
              cnt = $urandom_range(0, 2);
            end
          end
          if (model_pc[1:0] != 2'b00) check("misalign_req", 32'(imem_req_valid), 32'd0);
          if (done_next) begin
            exp_idv = model_pc[1:0] == 2'b00 && !mem_err(model_pc);
            check("entry_pc", program_count_out, model_pc);
            check("entry_pcv", 32'(program_count_valid_out), 32'd1);
            check("entry_idv", 32'(instruction_data_valid_out), 32'(exp_idv));
            if (exp_idv) check("entry_instr", instruction_data_out, mem_data(model_pc));
            if (!next_stall) begin
              model_pc = model_pc + 32'd4;
              transfers++;
            end else begin
              prev_hold = 1;
              prev_instr = instruction_data_out;
            end
          end
        end
      end
    end
    check("transfers_min", 32'(transfers >= 100), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
